// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the 256-bit L2 port between I$ and D$ misses.
// Requests are latched at grant; L2 is driven and answered from registers.
module l2_port_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  ipmem_address,
  input  logic         ipmem_read,
  output logic [255:0] ipmem_rdata,
  output logic         ipmem_resp,
  input  logic [31:0]  dpmem_address,
  input  logic [255:0] dpmem_wdata,
  input  logic         dpmem_read,
  input  logic         dpmem_write,
  output logic [255:0] dpmem_rdata,
  output logic         dpmem_resp,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RSP_I,
    RSP_D
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rdata_q, rdata_d;
  logic           wr_q, wr_d;
  logic           last_gnt_q, last_gnt_d;
  logic           mask_i_q, mask_i_d;
  logic           mask_d_q, mask_d_d;
  logic           perr_q, perr_d;

  logic req_i, req_d, pick_i, pick_d;

  assign req_i  = ipmem_read & ~mask_i_q;
  assign req_d  = (dpmem_read | dpmem_write) & ~mask_d_q;
  // On contention the side not served last wins
  assign pick_d = req_d & (~req_i | ~last_gnt_q);
  assign pick_i = req_i & ~pick_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wr_d       = wr_q;
    last_gnt_d = last_gnt_q;
    perr_d     = perr_q;
    mask_i_d   = 1'b0;
    mask_d_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d: begin
            state_d    = GNT_D;
            addr_d     = dpmem_address;
            wdata_d    = dpmem_wdata;
            wr_d       = dpmem_write;
            last_gnt_d = 1'b1;
            perr_d     = perr_q | (dpmem_read & dpmem_write);
          end
          pick_i: begin
            state_d    = GNT_I;
            addr_d     = ipmem_address;
            wr_d       = 1'b0;
            last_gnt_d = 1'b0;
          end
          default: ;
        endcase
      end
      GNT_I: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RSP_I;
        end
      end
      GNT_D: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RSP_D;
        end
      end
      RSP_I: begin
        state_d  = IDLE;
        mask_i_d = 1'b1;
      end
      RSP_D: begin
        state_d  = IDLE;
        mask_d_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
      last_gnt_q <= 1'b0;
      mask_i_q   <= 1'b0;
      mask_d_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wr_q       <= wr_d;
      last_gnt_q <= last_gnt_d;
      mask_i_q   <= mask_i_d;
      mask_d_q   <= mask_d_d;
      perr_q     <= perr_d;
    end
  end

  logic in_gnt;
  assign in_gnt = (state_q == GNT_I) | (state_q == GNT_D);

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_read    = in_gnt & ~wr_q;
  assign pmem_write   = (state_q == GNT_D) & wr_q;
  assign ipmem_rdata  = rdata_q;
  assign dpmem_rdata  = rdata_q;
  assign ipmem_resp   = (state_q == RSP_I);
  assign dpmem_resp   = (state_q == RSP_D);
  assign proto_err    = perr_q;

endmodule
